trans_debounce: RTL and testbench
=================================

TRANS_DEBOUNCE -- requirements
Module: trans_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples required to accept a new level (legal range 1..65535).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port d_i  input  1  raw asynchronous data (pin or bench stimulus).
REQ-006 SHALL have port d_o  output  1  debounced level; drives d_i of the downstream transparent D latch.
REQ-007 SHALL have port rise_o  output  1  one-cycle pulse on accepted 0->1 of d_o.
REQ-008 SHALL have port fall_o  output  1  one-cycle pulse on accepted 1->0 of d_o.
REQ-009 SHALL have port busy_o  output  1  high while a candidate level is being qualified.

Function
REQ-010 SHALL pass d_i through a SYNC_STAGES-deep flop chain; the last stage is the synchronized sample s.
REQ-011 SHALL implement FSM states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO, plus a counter cnt of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 SHALL, in STABLE_LO with s=1, go to CHECK_HI with cnt=0; in STABLE_HI with s=0, go to CHECK_LO with cnt=0.
REQ-013 SHALL, in CHECK_x with s equal to the candidate and cnt=DEBOUNCE_CYCLES-1, go to STABLE_x and update d_o to the candidate on the same edge.
REQ-014 SHALL, in CHECK_x with s equal to the candidate and cnt<DEBOUNCE_CYCLES-1, increment cnt.
REQ-015 SHALL, in CHECK_x with s not equal to the candidate, return to the previous STABLE state with cnt=0 and d_o unchanged.
REQ-016 SHALL change d_o exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples a new d_i level held constant; this is 7 edges with the defaults.
REQ-017 SHALL never let glitches shorter than DEBOUNCE_CYCLES synchronized cycles reach d_o.
REQ-018 SHALL drive rise_o and fall_o from registers, high for exactly the one cycle in which d_o holds its new value; they are never both high.
REQ-019 SHALL drive busy_o as a registered state decode: 1 in CHECK_HI and CHECK_LO, otherwise 0.
REQ-020 SHALL saturate cnt and never wrap it; the counter path is unaffected by DEBOUNCE_CYCLES=65535.
REQ-021 SHALL, with DEBOUNCE_CYCLES=1, accept a level after a single CHECK cycle.

Reset
REQ-022 SHALL, on rst_ni=0, immediately clear all synchronizer flops and cnt, set the FSM to STABLE_LO, and drive d_o=0, rise_o=0, fall_o=0 and busy_o=0.
REQ-023 SHALL discard any in-progress qualification when reset is asserted mid-CHECK; no edge pulse is emitted.
REQ-024 SHALL resume on the first rising clk_i edge after rst_ni deasserts; d_i=1 at release qualifies as a normal rise.

Configuration
REQ-025 SHALL gate the edge-pulse logic with macro TRANS_DEBOUNCE_EDGE_EN.
REQ-026 SHALL, when TRANS_DEBOUNCE_EDGE_EN is defined, implement rise_o and fall_o per REQ-018.
REQ-027 SHALL, when TRANS_DEBOUNCE_EDGE_EN is undefined, keep rise_o and fall_o as ports tied to constant 0, omit their registers, and leave d_o and busy_o behaviour unchanged.

Verification
REQ-028 Bench SHALL cover, with defaults and 20 ns clock: reset, then d_i 0->1 held for 200 ns -> d_o rises on the 7th edge, rise_o high for 1 cycle, busy_o high for 4 cycles before it.
REQ-029 Bench SHALL cover: d_i pulses 1 for 5, 10 and 30 ns around clock edges, as in the latch bench toggle pattern -> d_o stays 0, rise_o never asserts, busy_o returns to 0.
REQ-030 Bench SHALL cover: d_o=1 stable, then d_i=0 held -> d_o falls after 7 edges, fall_o is a single pulse, rise_o stays 0.
REQ-031 Bench SHALL cover: rst_ni pulled low during CHECK_HI (cnt=2) -> outputs are 0 within the same time step, and no pulse appears after release.
REQ-032 Bench SHALL cover: DEBOUNCE_CYCLES=1 with TRANS_DEBOUNCE_EDGE_EN undefined -> d_o follows held d_i after 4 edges, and rise_o and fall_o stay 0 throughout.

Source files
------------

// File: rtl/trans_debounce.sv
// Two-flop-plus synchronizer followed by a four-state debounce FSM with an optional edge-pulse stage.
// Optional feature macro: TRANS_DEBOUNCE_EDGE_EN enables registered rise_o/fall_o pulses.
`timescale 1ns/1ps
module trans_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic d_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StStableLo,
        StCheckHi,
        StStableHi,
        StCheckLo
    } state_e;

    state_e                   state_q, state_d;
    logic   [CntW-1:0]        cnt_q, cnt_d;
    logic   [SYNC_STAGES-1:0] sync_q;
    logic                     d_q, d_d;
    logic                     busy_q, busy_d;
    logic                     s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        unique case (state_q)
            StStableLo: begin
                if (s) begin
                    state_d = StCheckHi;
                    cnt_d   = '0;
                end
            end
            StCheckHi: begin
                if (!s) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q >= CntLast) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    d_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStableHi: begin
                if (!s) begin
                    state_d = StCheckLo;
                    cnt_d   = '0;
                end
            end
            StCheckLo: begin
                if (s) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q >= CntLast) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    d_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == StCheckHi) || (state_d == StCheckLo);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    assign d_o    = d_q;
    assign busy_o = busy_q;

`ifdef TRANS_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    // Pulses land on the same edge as the d_o update, so they overlap its first new-value cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= d_d & ~d_q;
            fall_q <= ~d_d & d_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_trans_debounce.sv
// Directed bench for trans_debounce: default instance plus a DEBOUNCE_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_trans_debounce;

`ifdef TRANS_DEBOUNCE_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic d, d1;
    logic d_o, rise, fall, busy;
    logic d1_o, rise1, fall1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    trans_debounce dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (d),
        .d_o    (d_o),
        .rise_o (rise),
        .fall_o (fall),
        .busy_o (busy)
    );

    trans_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (d1),
        .d_o    (d1_o),
        .rise_o (rise1),
        .fall_o (fall1),
        .busy_o (busy1)
    );

    typedef struct {
        logic rst;
        logic d;
        logic exp_d;
        logic exp_rise;
        logic exp_fall;
        logic exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic di, input logic ed, input logic er,
                       input logic ef, input logic eb);
        vec_t v;
        v.rst = r; v.d = di; v.exp_d = ed; v.exp_rise = er; v.exp_fall = ef; v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %b, expected %b", name, idx, $time, act, exp);
        end
    endtask

    task automatic glitch(input string name, input int pre, input int width);
        logic busy_seen;
        busy_seen = 1'b0;
        @(posedge clk);
        #pre d = 1'b1;
        #width d = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check({name, "_d_o"}, k, d_o, 1'b0);
            check({name, "_rise"}, k, rise, 1'b0);
            busy_seen = busy_seen | busy;
        end
        check({name, "_busy_end"}, 0, busy, 1'b0);
        check({name, "_busy_seen"}, 0, busy_seen, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d     = 1'b0;
        d1    = 1'b0;

        // rst, d, exp d_o, rise, fall, busy  (one row per clock edge)
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        // release with d=1: edges 1..10
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        // fall: edges 1..10
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        // single-cycle glitch: one CHECK cycle, then back
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst;
            d     = vecs[i].d;
            @(posedge clk);
            #1;
            check("tbl_d_o", i, d_o, vecs[i].exp_d);
            check("tbl_rise", i, rise, vecs[i].exp_rise & EdgeEn);
            check("tbl_fall", i, fall, vecs[i].exp_fall & EdgeEn);
            check("tbl_busy", i, busy, vecs[i].exp_busy);
        end

        // sub-cycle pulses straddling a rising edge
        glitch("g5", 17, 5);
        glitch("g10", 15, 10);
        glitch("g30", 15, 30);

        // reset asserted mid-qualification (cnt=2)
        @(negedge clk);
        d = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy_pre", 0, busy, 1'b1);
        #4 rst_n = 1'b0;
        #1;
        check("rst_d_o", 0, d_o, 1'b0);
        check("rst_rise", 0, rise, 1'b0);
        check("rst_fall", 0, fall, 1'b0);
        check("rst_busy", 0, busy, 1'b0);
        @(negedge clk);
        d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_rise", k, rise, 1'b0);
            check("post_rst_d_o", k, d_o, 1'b0);
            check("post_rst_busy", k, busy, 1'b0);
        end

        // DEBOUNCE_CYCLES=1 instance: accept after 4 edges each way
        @(negedge clk);
        d1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check("d1_rise_d_o", k, d1_o, k >= 4);
            check("d1_rise_busy", k, busy1, k == 3);
            check("d1_rise_rise", k, rise1, EdgeEn && (k == 4));
            check("d1_rise_fall", k, fall1, 1'b0);
        end
        @(negedge clk);
        d1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check("d1_fall_d_o", k, d1_o, k < 4);
            check("d1_fall_busy", k, busy1, k == 3);
            check("d1_fall_rise", k, rise1, 1'b0);
            check("d1_fall_fall", k, fall1, EdgeEn && (k == 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
